if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage pipeline: owns the program counter, drives the instruction-memory address, computes PC+1 with the 16-bit ripple adder, and registers the fetched instruction into the IF/ID pipeline register. It sits upstream of decode. It takes stall/flush from the hazard unit and redirects from the EX-stage branch resolution. A two-state run/halt machine stops fetch on a HALT opcode.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0000, bubble encoding written into IF/ID on flush/halt
- HALT_OPCODE, 4'hF, instr[15:12] value that stops fetch

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
- stall  in  1  hold PC and IF/ID (load-use hazard)
- flush  in  1  squash IF/ID contents to a bubble
- branch_taken  in  1  redirect PC this edge
- branch_target  in  16  redirect address (word address)
- imem_addr  out  16  instruction memory address; equals PC combinationally
- imem_data  in  16  instruction at imem_addr, combinational read
- if_id_instr  out  16  registered instruction
- if_id_pc1  out  16  registered PC+1 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  state == HALT

## Operation
- Reset values: PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc1=16'h0000, if_id_valid=0, halted=0, state=RUN.
- PC+1: adder a=PC, b=16'h0000, cin=1. Carry-out discarded, so 16'hFFFF wraps to 16'h0000 with no flag.
- States: RUN, HALT.
- Per-edge priority, highest first:
  - rst: apply reset values.
  - branch_taken: PC<=branch_target. IF/ID<=bubble (instr=NOP_INSTR, valid=0, pc1=0). State<=RUN. This overrides stall and HALT.
  - flush: IF/ID<=bubble. PC advances to PC+1 unless stall is also high, in which case PC holds.
  - stall: PC and IF/ID hold all fields.
  - HALT with none of the above: PC holds; IF/ID<=bubble.
  - RUN normal: IF/ID<={imem_data, PC+1, valid=1}. PC<=PC+1, except when imem_data[15:12]==HALT_OPCODE: then PC holds, the HALT instruction is still latched with valid=1, and state<=HALT.
- HALT detection applies only on a normal RUN load. A HALT word seen during stall, flush or branch is not acted on.
- HALT is left only by branch_taken or rst.

## Timing
- imem_addr tracks PC with zero latency; no registered memory.
- Fetch-to-IF/ID latency: 1 cycle. The instruction at PC at edge N is in if_id_instr after edge N.
- Redirect: branch_taken at edge N puts a bubble in IF/ID after N. The target instruction appears after edge N+1. Exactly one bubble from this stage.
- halted rises the cycle after the HALT word is latched, i.e. in the same cycle if_id_instr shows the HALT word.
- Reset mid-operation: asynchronous clear regardless of clock, stall or state. The first fetch after deassertion is RESET_PC.
- stall and flush in the same cycle: the bubble wins in IF/ID; PC holds.

## Structure
- Shared pipeline package holds: NOP_INSTR encoding, HALT_OPCODE, opcode field position [15:12], 16-bit word typedef. Decode reuses these.
- One sub-module: the existing adder_16bit, instantiated as the PC incrementer. PC register, state flop and IF/ID register stay in this module.

## Test plan
- Reset then free run, memory word i = 16'h1000+i: IF/ID shows 16'h1000 with pc1=1, then 16'h1001 with pc1=2; valid=1 from the first edge after reset.
- Stall held 2 cycles at PC=5: IF/ID and PC frozen for 2 cycles, then resume at PC=6 with no skipped or duplicated instruction.
- branch_taken with target 16'h0040 while stall=1: the next cycle shows PC=16'h0040 and a bubble (valid=0, instr=NOP_INSTR); the following cycle shows instr at 16'h0040, pc1=16'h0041.
- RESET_PC=16'hFFFE: fetches at FFFE, FFFF, then 0000; pc1 values are FFFF, 0000, 0001.
- HALT word 16'hF123 at address 3: IF/ID shows F123 valid=1 with halted=1; afterwards bubbles with PC stuck at 3. A later branch_taken to 16'h0010 clears halted and fetches from 16'h0010.
- rst asserted asynchronously mid-cycle while halted: outputs go to reset values immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: word type, opcode field, bubble and HALT encodings.
package if_stage_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned OPC_LSB = 12;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [OPC_W-1:0]  opcode_t;

    localparam word_t   NOP_INSTR   = 16'h0000;
    localparam opcode_t HALT_OPCODE = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // IF/ID pipeline register payload
    typedef struct packed {
        word_t instr;
        word_t pc1;
        logic  valid;
    } if_id_t;

    // Extract the opcode field instr[15:12]
    function automatic opcode_t opcode_of(input word_t w);
        return w[OPC_LSB +: OPC_W];
    endfunction

endpackage

// File: rtl/if_stage_adder.sv
// 16-bit ripple-carry adder, used as the PC incrementer.
module adder_16bit
    import if_stage_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [WORD_W:0] carry;

    // Ripple the carry through one full adder per bit
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[WORD_W];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem addressing, PC+1 and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter word_t   RESET_PC    = 16'h0000,
    parameter word_t   NOP_INSTR   = if_stage_pkg::NOP_INSTR,
    parameter opcode_t HALT_OPCODE = if_stage_pkg::HALT_OPCODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    output logic [WORD_W-1:0] if_id_instr,
    output logic [WORD_W-1:0] if_id_pc1,
    output logic              if_id_valid,
    output logic              halted
);

    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc1: '0, valid: 1'b0};

    state_t state_q, state_d;
    word_t  pc_q, pc_d;
    if_id_t ifid_q, ifid_d;
    word_t  pc_plus1;
    logic   pc1_cout_unused;
    logic   is_halt_word;

    // PC incrementer; wrap at 16'hFFFF is intentional, carry is dropped
    adder_16bit u_pc_inc (
        .a    (pc_q),
        .b    (16'h0000),
        .cin  (1'b1),
        .sum  (pc_plus1),
        .cout (pc1_cout_unused)
    );

    assign is_halt_word = (opcode_of(imem_data) == HALT_OPCODE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter HALT only on a normal RUN load of a HALT word
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = ST_RUN;
        end else if (!flush && !stall && (state_q == ST_RUN) && is_halt_word) begin
            state_d = ST_HALT;
        end
    end

    // Output decode from the state flop
    always_comb begin
        halted = 1'b0;
        if (state_q == ST_HALT) begin
            halted = 1'b1;
        end
    end

    // Next PC and IF/ID contents, highest-priority event first
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (branch_taken) begin
            pc_d   = branch_target;
            ifid_d = BUBBLE;
        end else if (flush) begin
            ifid_d = BUBBLE;
            if (!stall) begin
                pc_d = pc_plus1;
            end
        end else if (stall) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
        end else if (state_q == ST_HALT) begin
            ifid_d = BUBBLE;
        end else begin
            ifid_d = '{instr: imem_data, pc1: pc_plus1, valid: 1'b1};
            if (!is_halt_word) begin
                pc_d = pc_plus1;
            end
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            ifid_q <= BUBBLE;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = ifid_q.instr;
    assign if_id_pc1   = ifid_q.pc1;
    assign if_id_valid = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: driver pushes model predictions, monitor compares.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc1;
    logic        if_id_valid;
    logic        halted;

    logic [15:0] w_imem_addr;
    logic [15:0] w_imem_data;
    logic [15:0] w_if_id_instr;
    logic [15:0] w_if_id_pc1;
    logic        w_if_id_valid;
    logic        w_halted;

    logic [15:0] mem [65536];

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc1;
        logic [15:0] pc;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pc1;
    logic        m_valid;
    logic        m_halt;

    if_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc1     (if_id_pc1),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    if_stage #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (w_imem_addr),
        .imem_data     (w_imem_data),
        .if_id_instr   (w_if_id_instr),
        .if_id_pc1     (w_if_id_pc1),
        .if_id_valid   (w_if_id_valid),
        .halted        (w_halted)
    );

    assign imem_data   = mem[imem_addr];
    assign w_imem_data = mem[w_imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic m_reset();
        m_pc    = 16'h0000;
        m_instr = 16'h0000;
        m_pc1   = 16'h0000;
        m_valid = 1'b0;
        m_halt  = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle, predict the post-edge state and queue it
    task automatic step(input logic s, input logic f, input logic b, input logic [15:0] t);
        exp_t        e;
        logic [15:0] w;
        logic [15:0] p1;
        @(negedge clk);
        rst           = 1'b0;
        stall         = s;
        flush         = f;
        branch_taken  = b;
        branch_target = t;
        w  = mem[m_pc];
        p1 = m_pc + 16'd1;
        if (b) begin
            m_pc = t; m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else if (f) begin
            m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0;
            if (!s) m_pc = p1;
        end else if (s) begin
            // everything holds
        end else if (m_halt) begin
            m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0;
        end else begin
            m_instr = w; m_pc1 = p1; m_valid = 1'b1;
            if (w[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = p1;
        end
        e.instr  = m_instr;
        e.pc1    = m_pc1;
        e.pc     = m_pc;
        e.valid  = m_valid;
        e.halted = m_halt;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT against the oldest queued prediction after each edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_instr",  if_id_instr,       e.instr);
            chk("sb_pc1",    if_id_pc1,         e.pc1);
            chk("sb_valid",  16'(if_id_valid),  16'(e.valid));
            chk("sb_halted", 16'(halted),       16'(e.halted));
            chk("sb_addr",   imem_addr,         e.pc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(32'h1000 + i);
        m_reset();
        #12;

        // Reset values
        chk("rst_instr",  if_id_instr,      16'h0000);
        chk("rst_pc1",    if_id_pc1,        16'h0000);
        chk("rst_valid",  16'(if_id_valid), 16'h0000);
        chk("rst_halted", 16'(halted),      16'h0000);
        chk("rst_addr",   imem_addr,        16'h0000);
        chk("rst_waddr",  w_imem_addr,      16'hFFFE);

        // Free run from reset, plus wrap-around on the FFFE instance
        step(0, 0, 0, 0);
        chk("run0_instr", if_id_instr, 16'h1000);
        chk("run0_pc1",   if_id_pc1,   16'h0001);
        chk("run0_valid", 16'(if_id_valid), 16'h0001);
        chk("wrap0_instr", w_if_id_instr, 16'h0FFE);
        chk("wrap0_pc1",   w_if_id_pc1,   16'hFFFF);
        step(0, 0, 0, 0);
        chk("run1_instr", if_id_instr, 16'h1001);
        chk("run1_pc1",   if_id_pc1,   16'h0002);
        chk("wrap1_instr", w_if_id_instr, 16'h0FFF);
        chk("wrap1_pc1",   w_if_id_pc1,   16'h0000);
        step(0, 0, 0, 0);
        chk("wrap2_instr", w_if_id_instr, 16'h1000);
        chk("wrap2_pc1",   w_if_id_pc1,   16'h0001);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_stall_addr", imem_addr, 16'h0005);

        // Two-cycle stall at PC=5
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("stall_instr", if_id_instr, 16'h1004);
        chk("stall_addr",  imem_addr,   16'h0005);
        step(0, 0, 0, 0);
        chk("resume_instr", if_id_instr, 16'h1005);
        chk("resume_pc1",   if_id_pc1,   16'h0006);

        // Branch overrides stall
        step(1, 0, 1, 16'h0040);
        chk("br_addr",  imem_addr,        16'h0040);
        chk("br_valid", 16'(if_id_valid), 16'h0000);
        chk("br_instr", if_id_instr,      16'h0000);
        step(0, 0, 0, 0);
        chk("br_tgt_instr", if_id_instr, 16'h1040);
        chk("br_tgt_pc1",   if_id_pc1,   16'h0041);

        // Flush with and without stall
        step(1, 1, 0, 0);
        chk("fs_addr", imem_addr, 16'h0041);
        step(0, 1, 0, 0);
        chk("f_addr", imem_addr, 16'h0042);

        // HALT at address 3, then escape by branch
        mem[3] = 16'hF123;
        step(0, 0, 1, 16'h0003);
        step(0, 0, 0, 0);
        chk("halt_instr",  if_id_instr,      16'hF123);
        chk("halt_valid",  16'(if_id_valid), 16'h0001);
        chk("halt_halted", 16'(halted),      16'h0001);
        chk("halt_addr",   imem_addr,        16'h0003);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("halted_valid", 16'(if_id_valid), 16'h0000);
        chk("halted_addr",  imem_addr,        16'h0003);
        step(1, 1, 0, 0);
        step(0, 0, 1, 16'h0010);
        chk("unhalt_halted", 16'(halted), 16'h0000);
        chk("unhalt_addr",   imem_addr,   16'h0010);
        step(0, 0, 0, 0);
        chk("unhalt_instr", if_id_instr, 16'h1010);

        // Asynchronous reset mid-cycle while halted
        step(0, 0, 1, 16'h0003);
        step(0, 0, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_instr",  if_id_instr,      16'h0000);
        chk("arst_pc1",    if_id_pc1,        16'h0000);
        chk("arst_valid",  16'(if_id_valid), 16'h0000);
        chk("arst_halted", 16'(halted),      16'h0000);
        chk("arst_addr",   imem_addr,        16'h0000);
        m_reset();
        step(0, 0, 0, 0);
        chk("arst_refetch", if_id_instr, 16'h1000);

        // Randomized traffic with random memory contents
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                #1;
                rst = 1'b1;
                #1;
                chk("rnd_arst_valid", 16'(if_id_valid), 16'h0000);
                chk("rnd_arst_addr",  imem_addr,        16'h0000);
                m_reset();
            end
            step(($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0),
                 16'($urandom_range(0, 1023)));
        end

        @(posedge clk);
        #3;
        chk("queue_drain", 16'(exp_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
